// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-perceptron datapath: default geometry,
// the column-streamer state encoding and small sizing helpers.
package snn_pkg;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_HEIGHT  = 7;
    localparam int DEF_REPEATS = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

    // Number of words needed to carry a frame of frame_bits bits.
    function automatic int calc_n_words(input int frame_bits, input int word_w);
        return (frame_bits + word_w - 1) / word_w;
    endfunction

    // Index width that never collapses to zero for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// Frame store: written one word at a time by word index, read one
// HEIGHT-bit pixel column at a time by column index.
module frame_buffer
    import snn_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int N_WORDS = calc_n_words(WIDTH * HEIGHT, WORD_W),
    parameter int WIDX_W  = idx_width(N_WORDS),
    parameter int COL_W   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [WIDX_W-1:0] i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [COL_W-1:0]  i_col_idx,
    output logic [HEIGHT-1:0] o_col
);

    localparam int FRAME_BITS = WIDTH * HEIGHT;

    logic [FRAME_BITS-1:0] r_bits;
    logic [FRAME_BITS-1:0] w_merged [N_WORDS];
    logic [HEIGHT-1:0]     w_cols   [WIDTH];

    for (genvar k = 0; k < N_WORDS; k++) begin : g_word
        localparam int LO = k * WORD_W;
        localparam int HI = (((LO + WORD_W) < FRAME_BITS) ? (LO + WORD_W) : FRAME_BITS) - 1;
        localparam int NB = HI - LO + 1;

        // Candidate buffer contents if word k were written now; data bits that
        // fall beyond the end of the frame are simply not carried over.
        always_comb begin
            w_merged[k]        = r_bits;
            w_merged[k][HI:LO] = i_wr_data[NB-1:0];
        end
    end

    // Commit the selected word into the buffer.
    // NOTE: this storage is cleared on reset, so a bit that was never loaded
    // reads as a known 0 rather than whatever the flops powered up with.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bits <= '0;
        end else if (i_wr_en) begin
            r_bits <= w_merged[i_wr_idx];
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        assign w_cols[c] = r_bits[c*HEIGHT +: HEIGHT];
    end

    assign o_col = w_cols[i_col_idx];

endmodule

// File: rtl/image_column_streamer.sv
// Buffers a frame delivered as a burst of words, kicks the network with a
// start pulse, then replays the frame column by column REPEATS times, one
// column per network step, and finishes with a done pulse.
module image_column_streamer
    import snn_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int REPEATS = DEF_REPEATS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         word_valid,
    input  logic [WORD_W-1:0]            word_data,
    output logic                         word_ready,
    input  logic                         abort,
    input  logic                         step,
    output logic                         start_net,
    output logic [HEIGHT-1:0]            pixels,
    output logic [$clog2(WIDTH)-1:0]     col_idx,
    output logic [$clog2(REPEATS+1)-1:0] pass_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int FRAME_BITS = WIDTH * HEIGHT;
    localparam int N_WORDS    = calc_n_words(FRAME_BITS, WORD_W);
    localparam int WIDX_W     = idx_width(N_WORDS);
    localparam int COL_W      = $clog2(WIDTH);
    localparam int PASS_W     = $clog2(REPEATS + 1);

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(N_WORDS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEATS - 1);

    stream_state_t     r_state,    w_state_nxt;
    logic [WIDX_W-1:0] r_word_cnt, w_word_cnt_nxt;
    logic [COL_W-1:0]  r_col,      w_col_nxt;
    logic [PASS_W-1:0] r_pass,     w_pass_nxt;
    logic              w_wr_en;
    logic              w_busy;
    logic [HEIGHT-1:0] w_col_data;

    // State and counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_LOAD;
            r_word_cnt <= '0;
            r_col      <= '0;
            r_pass     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_col      <= w_col_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    // Next-state, counter and buffer-write decisions; abort overrides all.
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_col_nxt      = r_col;
        w_pass_nxt     = r_pass;
        w_wr_en        = 1'b0;

        unique case (r_state)
            ST_LOAD: begin
                if (word_valid) begin
                    w_wr_en = 1'b1;
                    if (r_word_cnt == LAST_WORD) begin
                        w_state_nxt    = ST_START;
                        w_word_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            ST_START: begin
                // The network is being reset this cycle; a step here is stale.
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (step) begin
                    if (r_col != LAST_COL) begin
                        w_col_nxt = r_col + 1'b1;
                    end else if (r_pass != LAST_PASS) begin
                        w_col_nxt  = '0;
                        w_pass_nxt = r_pass + 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt    = ST_LOAD;
                w_word_cnt_nxt = '0;
                w_col_nxt      = '0;
                w_pass_nxt     = '0;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase

        if (abort) begin
            w_state_nxt    = ST_LOAD;
            w_word_cnt_nxt = '0;
            w_col_nxt      = '0;
            w_pass_nxt     = '0;
            w_wr_en        = 1'b0;
        end
    end

    frame_buffer #(
        .WORD_W  (WORD_W),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .N_WORDS (N_WORDS),
        .WIDX_W  (WIDX_W),
        .COL_W   (COL_W)
    ) u_frame_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_word_cnt),
        .i_wr_data (word_data),
        .i_col_idx (r_col),
        .o_col     (w_col_data)
    );

    // Outputs are pure decodes of registered state, counters and buffer
    // contents, so nothing ripples from the inputs straight to the outputs.
    assign w_busy     = (r_state == ST_START) || (r_state == ST_STREAM);
    assign word_ready = (r_state == ST_LOAD);
    assign start_net  = (r_state == ST_START);
    assign done       = (r_state == ST_DONE);
    assign busy       = w_busy;
    assign pixels     = w_busy ? w_col_data : '0;
    assign col_idx    = r_col;
    assign pass_idx   = r_pass;

endmodule
